// File: rtl/gf180mcu_osu_sc_gp12t3v3__inv_pipe_pkg.sv
// gf180mcu_osu_sc_gp12t3v3__inv_pipe_pkg: size limits, parameter checks, scan index helper.
// Rev 1.0
`default_nettype none

package gf180mcu_osu_sc_gp12t3v3__inv_pipe_pkg;

  localparam int MAX_DEPTH = 8;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_ok(input int width);
    return (width >= 1) && (width <= MAX_WIDTH);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 1) && (depth <= MAX_DEPTH);
  endfunction

  // Position of a data bit in the serial scan chain.
  function automatic int scan_index(input int stage, input int bit_idx, input int width);
    return stage * width + bit_idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_osu_sc_gp12t3v3__inv_pipe_if.sv
// gf180mcu_osu_sc_gp12t3v3__inv_pipe_if: data/valid/enable bundle of the inverting pipeline.
// Rev 1.0
`default_nettype none

interface gf180mcu_osu_sc_gp12t3v3__inv_pipe_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic [WIDTH-1:0] A;
  logic             AV;
  logic [WIDTH-1:0] Y;
  logic             YV;

  modport master (output EN, output A, output AV, input Y, input YV);
  modport slave  (input EN, input A, input AV, output Y, output YV);
endinterface

`default_nettype wire

// File: rtl/gf180mcu_osu_sc_gp12t3v3__inv_pipe_stage.sv
// gf180mcu_osu_sc_gp12t3v3__inv_pipe_stage: one data+valid register stage with hold and optional scan
// (GF180MCU_OSU_SC_INV_PIPE_SCAN_EN). Rev 1.0
`default_nettype none

module gf180mcu_osu_sc_gp12t3v3__inv_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
  input  logic             se,
  input  logic             si,
`endif
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
  logic [WIDTH-1:0] scan_shift;

  if (WIDTH == 1) begin : g_scan_w1
    assign scan_shift = si;
  end else begin : g_scan_wn
    assign scan_shift = {data_q[WIDTH-2:0], si};
  end
`endif

  // Ternary select keeps an unknown enable pessimistic in simulation.
  always_comb begin
    data_d  = en ? d : data_q;
    valid_d = en ? v : valid_q;
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
    if (se) begin
      data_d  = scan_shift;
      valid_d = valid_q;
    end
`endif
    if (!rn) begin
      data_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    data_q  <= data_d;
    valid_q <= valid_d;
  end

  assign q  = data_q;
  assign qv = valid_q;

endmodule

`default_nettype wire

// File: rtl/gf180mcu_osu_sc_gp12t3v3__inv_pipe.sv
// gf180mcu_osu_sc_gp12t3v3__inv_pipe: per-bit programmable inverter feeding a DEPTH-stage valid-tagged
// pipeline; optional scan chain under GF180MCU_OSU_SC_INV_PIPE_SCAN_EN. Rev 1.0
`default_nettype none

module gf180mcu_osu_sc_gp12t3v3__inv_pipe
  import gf180mcu_osu_sc_gp12t3v3__inv_pipe_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
  input  logic CLK,
  input  logic RN,
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
  input  logic SE,
  input  logic SI,
  output logic SO,
`endif
  gf180mcu_osu_sc_gp12t3v3__inv_pipe_if.slave bus
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("inv_pipe: WIDTH out of range");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("inv_pipe: DEPTH out of range");
  end

  logic [WIDTH-1:0] stg_data  [DEPTH];
  logic             stg_valid [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
    logic             s_in;
`endif

    if (k == 0) begin : g_head
      assign d_in = bus.A ^ INV_MASK;
      assign v_in = bus.AV;
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
      assign s_in = SI;
`endif
    end else begin : g_tail
      assign d_in = stg_data[k-1];
      assign v_in = stg_valid[k-1];
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
      assign s_in = stg_data[k-1][WIDTH-1];
`endif
    end

    gf180mcu_osu_sc_gp12t3v3__inv_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk (CLK),
      .rn  (RN),
      .en  (bus.EN),
      .d   (d_in),
      .v   (v_in),
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
      .se  (SE),
      .si  (s_in),
`endif
      .q   (stg_data[k]),
      .qv  (stg_valid[k])
    );
  end

  assign bus.Y  = stg_data[DEPTH-1];
  assign bus.YV = stg_valid[DEPTH-1];

`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
  assign SO = stg_data[DEPTH-1][WIDTH-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__inv_pipe.sv
// tb_gf180mcu_osu_sc_gp12t3v3__inv_pipe: checks a DEPTH=2/mask F and a DEPTH=1/mask 0101 instance
// against a timeline model of accepted samples. Rev 1.0
`default_nettype none

module tb_gf180mcu_osu_sc_gp12t3v3__inv_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rn;
  logic [W-1:0] a;
  logic         av;
  logic         en;
  int           total = 0;
  int           bad   = 0;

  // Each entry is {valid, data} as seen at the pipe output, newest last.
  logic [W:0]   h0[$];
  logic [W:0]   h1[$];

  always #5 clk = ~clk;

  gf180mcu_osu_sc_gp12t3v3__inv_pipe_if #(.WIDTH(W)) bus0 ();
  gf180mcu_osu_sc_gp12t3v3__inv_pipe_if #(.WIDTH(W)) bus1 ();

  assign bus0.A  = a;
  assign bus0.AV = av;
  assign bus0.EN = en;
  assign bus1.A  = a;
  assign bus1.AV = av;
  assign bus1.EN = en;

`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
  logic se;
  logic si;
  logic so0;
  logic so1;
`endif

  gf180mcu_osu_sc_gp12t3v3__inv_pipe #(
    .WIDTH(W), .DEPTH(2), .INV_MASK(4'hF)
  ) dut0 (
    .CLK (clk),
    .RN  (rn),
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
    .SE  (se),
    .SI  (si),
    .SO  (so0),
`endif
    .bus (bus0)
  );

  gf180mcu_osu_sc_gp12t3v3__inv_pipe #(
    .WIDTH(W), .DEPTH(1), .INV_MASK(4'b0101)
  ) dut1 (
    .CLK (clk),
    .RN  (rn),
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
    .SE  (se),
    .SI  (si),
    .SO  (so1),
`endif
    .bus (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the timeline model, compare the outputs.
  task automatic step(input logic [W-1:0] ia, input logic iav, input logic ien, input logic irn);
    logic [W:0] e0;
    logic [W:0] e1;
    a  = ia;
    av = iav;
    en = ien;
    rn = irn;
    @(posedge clk);
    if (!irn) begin
      // Reset clears every stage: DEPTH blank entries reach the output.
      h0.push_back('0);
      h0.push_back('0);
      h1.push_back('0);
    end else if (ien) begin
      h0.push_back({iav, ia ^ 4'hF});
      h1.push_back({iav, ia ^ 4'b0101});
    end
    #1;
    e0 = h0[h0.size()-2];
    e1 = h1[h1.size()-1];
    chk("yv0", {31'd0, bus0.YV}, {31'd0, e0[W]});
    chk("yv1", {31'd0, bus1.YV}, {31'd0, e1[W]});
    if (e0[W] || !irn) chk("y0", {28'd0, bus0.Y}, {28'd0, e0[W-1:0]});
    if (e1[W] || !irn) chk("y1", {28'd0, bus1.Y}, {28'd0, e1[W-1:0]});
  endtask

  initial begin
    a  = '0;
    av = 1'b0;
    en = 1'b0;
    rn = 1'b0;
`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
    se = 1'b0;
    si = 1'b0;
`endif

    step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b0);

    // Latency / inversion: 3 through the 2-deep all-ones pipe.
    step(4'h3, 1'b1, 1'b1, 1'b1);
    chk("lat_pre_yv", {31'd0, bus0.YV}, 32'd0);
    step(4'h0, 1'b0, 1'b1, 1'b1);
    chk("lat_y", {28'd0, bus0.Y}, 32'hC);

    // Partial mask on the 1-deep instance.
    step(4'hF, 1'b1, 1'b1, 1'b1);
    chk("mask_f", {28'd0, bus1.Y}, 32'hA);
    step(4'h0, 1'b1, 1'b1, 1'b1);
    chk("mask_0", {28'd0, bus1.Y}, 32'h5);

    // Stall: 1 enters, three stalled cycles with junk on A.
    step(4'h1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(W'($urandom_range(15)), 1'b1, 1'b0, 1'b1);
    step(4'h9, 1'b0, 1'b1, 1'b1);
    chk("stall_y", {28'd0, bus0.Y}, 32'hE);

    // Reset mid-flight flushes both valid samples.
    step(4'h5, 1'b1, 1'b1, 1'b1);
    step(4'h6, 1'b1, 1'b1, 1'b1);
    step(4'h7, 1'b1, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b1);
    step(4'h0, 1'b0, 1'b1, 1'b1);

    // Bubble pattern.
    step(4'h1, 1'b1, 1'b1, 1'b1);
    step(4'h2, 1'b0, 1'b1, 1'b1);
    step(4'h3, 1'b1, 1'b1, 1'b1);
    step(4'h0, 1'b0, 1'b1, 1'b1);
    step(4'h0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with stalls, bubbles and occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(W'($urandom_range(15)), 1'($urandom_range(1)),
           ($urandom_range(3) != 0), ($urandom_range(19) != 0));
    end

`ifdef GF180MCU_OSU_SC_INV_PIPE_SCAN_EN
    begin
      logic [7:0] pat;
      pat = 8'b1011_0010;
      step(4'h0, 1'b1, 1'b1, 1'b0);
      step(4'h0, 1'b1, 1'b1, 1'b1);
      step(4'h0, 1'b1, 1'b1, 1'b1);
      se = 1'b1;
      for (int i = 0; i < 15; i++) begin
        si = (i < 8) ? pat[i] : 1'b0;
        av = 1'($urandom_range(1));
        @(posedge clk);
        #1;
        chk("scan_yv", {31'd0, bus0.YV}, 32'd1);
        if (i >= 7) chk("scan_so", {31'd0, so0}, {31'd0, pat[i-7]});
      end
      se = 1'b0;
      step(4'h0, 1'b0, 1'b1, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
